// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, count-decoded status flags and
// optional sticky overflow/underflow outputs (define SYNC_FIFO_ERR_FLAGS_EN).
module sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned ALMOST_FULL_TH  = 14,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  // A write into a full FIFO is allowed only because the same-edge read frees a slot.
  assign w_wr_ok = wr_en && (!full || rd_en);
  assign w_rd_ok = rd_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_en) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign rd_data      = r_rd_data;
  assign count        = r_count;
  assign full         = (r_count == CW'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(ALMOST_FULL_TH));
  assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_TH));

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: a queue model predicts contents and flags;
// predicted read words are queued on rd_en and popped when rd_data is sampled.
module tb_sync_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;
  localparam int unsigned AFT = 14;
  localparam int unsigned AET = 2;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEP),
    .ALMOST_FULL_TH(AFT),
    .ALMOST_EMPTY_TH(AET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned   n_total;
  int unsigned   n_bad;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;
  logic          m_ovf;
  logic          m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_status();
    int unsigned n;
    n = model_q.size();
    chk("count",        32'(count),        32'(n));
    chk("full",         32'(full),         32'(n == DEP));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= AFT));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AET));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
`endif
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    last_rd = '0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock of traffic: drive on the falling edge, check 1 time unit after the rising edge.
  task automatic cyc(input logic wr, input logic [DW-1:0] d, input logic rd);
    logic m_full;
    logic m_empty;
    logic rok;
    @(negedge clk);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    m_full  = (model_q.size() == DEP);
    m_empty = (model_q.size() == 0);
    rok     = rd && !m_empty;
    if (wr && m_full && !rd) m_ovf = 1'b1;
    if (rd && m_empty)       m_udf = 1'b1;
    if (rok) exp_q.push_back(model_q.pop_front());
    if (wr && (!m_full || rd)) model_q.push_back(d);
    @(posedge clk);
    #1;
    if (rok) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        last_rd = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(last_rd));
      end
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(last_rd));
    end
    chk_status();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    rst     = 1'b1;
    model_reset();
    #1;
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk_status();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of traffic, observed before any clock edge.
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0);
    cyc(1'b1, 8'hC5, 1'b1);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    rd_en   = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rd_data", 32'(rd_data), 32'(0));
    chk_status();
    repeat (3) @(posedge clk);
    #1;
    chk_status();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b0;

    // Fill to full.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(i), 1'b0);
    chk("filled_full", 32'(full), 32'(1));
    // Rejected write while full.
    cyc(1'b1, 8'hAA, 1'b0);
    // Simultaneous read and write while full: oldest word out, 0x55 queued last.
    cyc(1'b1, 8'h55, 1'b1);
    // Drain all 16.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drained_last", 32'(rd_data), 32'(8'h55));
    // Read while empty.
    cyc(1'b0, 8'h00, 1'b1);
    // Simultaneous read and write while empty: write only.
    cyc(1'b1, 8'h33, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);

    // Wrap-around: 40 words in bursts of five writes then five reads.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(b * 5 * 7 + i * 7 + 3), 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1);
    end
    // Mixed random traffic to exercise concurrent pointer movement.
    for (int i = 0; i < 200; i++) begin
      cyc(1'($urandom_range(1)), DW'($urandom_range(255)), 1'($urandom_range(1)));
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
